spwm_ctrl: RTL

- Run/fault sequencer and reference scheduler for the three-phase sine-PWM modulator.
- Accepts new phase references (x, y, z) and a new modulation index through a valid/ready handshake and holds them in a one-deep shadow buffer.
- Applies the buffered values only at carrier reversal points, which prevents mid-period glitches on the comparators.
- Owns the gate-enable and fault latch for the inverter bridge.

---
 rtl/spwm_ctrl_pkg.sv | 30 +++
 rtl/spwm_evt_det.sv | 57 +++++
 rtl/spwm_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spwm_ctrl_pkg.sv
// Shared definitions for the sine-PWM run/fault sequencer.
//
// Contents:
//   state_e    - sequencer state encoding (IDLE/ARM/RUN/FAULT)
//   dir_e      - carrier slope direction used by the event detector
//   ONE        - +1.0 in Q4.28
//   MINUS_ONE  - -1.0 in Q4.28
//   UPD_VALLEY - apply buffered references at carrier valleys only
//   UPD_BOTH   - apply buffered references at valleys and peaks
package spwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic signed [31:0] ONE       = 32'sh1000_0000;
  localparam logic signed [31:0] MINUS_ONE = 32'shF000_0000;

  localparam int UPD_VALLEY = 0;
  localparam int UPD_BOTH   = 1;

endpackage

// File: rtl/spwm_evt_det.sv
// Carrier reversal detector.
//
// Tracks the previous carrier sample and the current slope direction and
// flags the sample at which the triangle turns around. Usable by any block
// that must act synchronously with the carrier.
//
// Ports:
//   clk_i      in   system clock
//   rst_i      in   asynchronous active-high reset
//   carrier_i  in   signed triangle carrier sample (N bits)
//   valley_o   out  carrier started rising after falling (combinational)
//   peak_o     out  carrier started falling after rising (combinational)
module spwm_evt_det
  import spwm_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic signed [N-1:0] carrier_i,
  output logic                valley_o,
  output logic                peak_o
);

  logic signed [N-1:0] prev_c_q;
  dir_e                dir_q;
  dir_e                dir_d;
  logic                rising;
  logic                falling;

  // A flat sample (equal to the previous one) keeps the old direction so a
  // stalled carrier never produces a spurious reversal.
  always_comb begin
    rising  = carrier_i > prev_c_q;
    falling = carrier_i < prev_c_q;
    dir_d   = dir_q;
    if (rising) begin
      dir_d = DIR_UP;
    end else if (falling) begin
      dir_d = DIR_DOWN;
    end
  end

  assign valley_o = (dir_q == DIR_DOWN) && rising;
  assign peak_o   = (dir_q == DIR_UP) && falling;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_c_q <= '0;
      dir_q    <= DIR_UP;
    end else begin
      prev_c_q <= carrier_i;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: rtl/spwm_ctrl.sv
// Run/fault sequencer and reference scheduler for the three-phase sine-PWM
// modulator.
//
// New phase references and a modulation index are accepted through a
// valid/ready handshake into a one-deep shadow buffer, and copied to the
// active outputs only at carrier reversal points so the comparators never
// see a change in the middle of a carrier half period. The block also owns
// the bridge gate enable and the latched fault state.
//
// Ports:
//   clk_i        in   system clock
//   res_i        in   asynchronous active-high reset
//   en_i         in   run request
//   fault_i      in   bridge fault (level)
//   carrier_i    in   signed triangle carrier (N bits)
//   x_in_i       in   new phase x reference (N bits)
//   y_in_i       in   new phase y reference (N bits)
//   z_in_i       in   new phase z reference (N bits)
//   m_in_i       in   new modulation index (N bits)
//   ref_valid_i  in   reference set valid
//   ref_ready_o  out  shadow buffer free
//   x_o/y_o/z_o  out  active phase references (N bits each)
//   m_out_o      out  active modulation index (N bits)
//   gate_en_o    out  bridge gate enable (registered)
//   upd_o        out  one-cycle pulse after a transfer
//   underrun_o   out  saturating count of update points with nothing pending
//   state_o      out  sequencer state (0 IDLE, 1 ARM, 2 RUN, 3 FAULT)
module spwm_ctrl
  import spwm_ctrl_pkg::*;
#(
  parameter int                  N         = 32,
  parameter int                  Q         = 28,
  // Both defaults equal 1.0 in the chosen fixed-point format.
  parameter logic signed [N-1:0] LIMIT     = N'(64'sd1 <<< Q),
  parameter logic signed [N-1:0] M_DEFAULT = N'(64'sd1 <<< Q),
  parameter int                  UPD_MODE  = UPD_VALLEY
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic                en_i,
  input  logic                fault_i,
  input  logic signed [N-1:0] carrier_i,
  input  logic signed [N-1:0] x_in_i,
  input  logic signed [N-1:0] y_in_i,
  input  logic signed [N-1:0] z_in_i,
  input  logic signed [N-1:0] m_in_i,
  input  logic                ref_valid_i,
  output logic                ref_ready_o,
  output logic signed [N-1:0] x_o,
  output logic signed [N-1:0] y_o,
  output logic signed [N-1:0] z_o,
  output logic signed [N-1:0] m_out_o,
  output logic                gate_en_o,
  output logic                upd_o,
  output logic [15:0]         underrun_o,
  output logic [1:0]          state_o
);

  // Saturate a reference to [-LIMIT, +LIMIT].
  function automatic logic signed [N-1:0] sat(input logic signed [N-1:0] v);
    logic signed [N-1:0] r;
    r = v;
    if (v > LIMIT) begin
      r = LIMIT;
    end else if (v < -LIMIT) begin
      r = -LIMIT;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                pend_v_q, pend_v_d;
  logic signed [N-1:0] px_q, px_d;
  logic signed [N-1:0] py_q, py_d;
  logic signed [N-1:0] pz_q, pz_d;
  logic signed [N-1:0] pm_q, pm_d;
  logic signed [N-1:0] x_q, x_d;
  logic signed [N-1:0] y_q, y_d;
  logic signed [N-1:0] z_q, z_d;
  logic signed [N-1:0] m_q, m_d;
  logic                gate_en_q, gate_en_d;
  logic                upd_q, upd_d;
  logic [15:0]         underrun_q, underrun_d;

  logic valley;
  logic peak;
  logic evt;
  logic accept;
  logic xfer;
  logic under_inc;

  spwm_evt_det #(
    .N(N)
  ) u_evt_det (
    .clk_i     (clk_i),
    .rst_i     (res_i),
    .carrier_i (carrier_i),
    .valley_o  (valley),
    .peak_o    (peak)
  );

  assign evt = (UPD_MODE == UPD_BOTH) ? (valley | peak) : valley;

  // Ready is low while a set is pending, so acceptance and transfer can
  // never happen on the same edge.
  assign ref_ready_o = !pend_v_q;
  assign accept      = ref_valid_i && !pend_v_q;

  // Sequencer next state. A fault input overrides every other condition;
  // once in FAULT the state is held until both fault and en are low. A
  // dropped run request takes precedence over an update point.
  always_comb begin
    state_d   = state_q;
    xfer      = 1'b0;
    under_inc = 1'b0;
    if (fault_i) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (!en_i) begin
            state_d = ST_IDLE;
          end else if (evt && pend_v_q) begin
            xfer    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state_d = ST_IDLE;
          end else if (evt) begin
            if (pend_v_q) begin
              xfer = 1'b1;
            end else begin
              under_inc = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (!en_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shadow buffer. The fault input flushes it; a set offered during the
  // same cycle is discarded because the bridge is being shut down.
  always_comb begin
    pend_v_d = pend_v_q;
    px_d     = px_q;
    py_d     = py_q;
    pz_d     = pz_q;
    pm_d     = pm_q;
    if (fault_i) begin
      pend_v_d = 1'b0;
    end else if (accept) begin
      pend_v_d = 1'b1;
      px_d     = sat(x_in_i);
      py_d     = sat(y_in_i);
      pz_d     = sat(z_in_i);
      pm_d     = m_in_i;
    end else if (xfer) begin
      pend_v_d = 1'b0;
    end
  end

  // Active outputs are derived from the next state so the gate enable and
  // the zeroed references change on the same edge as the state itself.
  // The modulation index is never cleared; it keeps its last value outside
  // RUN.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    m_d        = m_q;
    gate_en_d  = (state_d == ST_RUN);
    upd_d      = xfer;
    underrun_d = underrun_q;
    if ((state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
      x_d = '0;
      y_d = '0;
      z_d = '0;
    end else if (xfer) begin
      x_d = px_q;
      y_d = py_q;
      z_d = pz_q;
      m_d = pm_q;
    end
    if (under_inc && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q    <= ST_IDLE;
      pend_v_q   <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pz_q       <= '0;
      pm_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      m_q        <= M_DEFAULT;
      gate_en_q  <= 1'b0;
      upd_q      <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pz_q       <= pz_d;
      pm_q       <= pm_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      m_q        <= m_d;
      gate_en_q  <= gate_en_d;
      upd_q      <= upd_d;
      underrun_q <= underrun_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign z_o        = z_q;
  assign m_out_o    = m_q;
  assign gate_en_o  = gate_en_q;
  assign upd_o      = upd_q;
  assign underrun_o = underrun_q;
  assign state_o    = state_q;

endmodule
